// File: rtl/sos_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : sos_pkg
//  Description : Shared types and helpers for the speed-of-sound delay
//                aligner: alignment FSM state encoding, the audio sample
//                rate and a saturating subtract.
//  Revision    : 1.0 - initial release
// ============================================================================
package sos_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILLING = 2'd1,
        ALIGNED = 2'd2
    } align_state_t;

    localparam int SAMPLE_RATE_HZ = 24000;

    // a - b evaluated exactly (operands are sign-extended samples of width w,
    // so the difference needs w+1 bits), then clamped to the signed range of
    // w bits. The caller keeps the low w bits of the result.
    function automatic logic signed [31:0] sat_sub(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w);
        logic signed [31:0] diff;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        diff = a - b;
        hi   = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo   = -(32'sd1 <<< (w - 1));
        if (diff > hi) begin
            return hi;
        end else if (diff < lo) begin
            return lo;
        end
        return diff;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sos_delay_aligner_sample_ram.sv
`default_nettype none
// ============================================================================
//  Module      : sample_ram
//  Description : DEPTH x DATA_W simple dual-port sample memory, one write
//                port and one registered read port (block-RAM style).
//  Ports       : clk_in     - clock
//                we_in      - write enable
//                waddr_in   - write address
//                wdata_in   - write data
//                re_in      - read enable; read data register only updates
//                             when set, so it holds between reads
//                raddr_in   - read address
//                rdata_out  - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_ram #(
    parameter int DEPTH  = 512,
    parameter int DATA_W = 16
) (
    input  logic                       clk_in,
    input  logic                       we_in,
    input  logic [$clog2(DEPTH)-1:0]   waddr_in,
    input  logic [DATA_W-1:0]          wdata_in,
    input  logic                       re_in,
    input  logic [$clog2(DEPTH)-1:0]   raddr_in,
    output logic [DATA_W-1:0]          rdata_out
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // No reset: contents are qualified by the fill logic in the parent.
    always_ff @(posedge clk_in) begin
        if (we_in) begin
            mem_q[waddr_in] <= wdata_in;
        end
        if (re_in) begin
            rdata_q <= mem_q[raddr_in];
        end
    end

    assign rdata_out = rdata_q;

endmodule
`default_nettype wire

// File: rtl/sos_delay_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : sos_delay_aligner
//  Description : Replays the speaker reference delayed by the measured
//                acoustic delay (in 24 kHz samples) and emits the saturated
//                residual mic - aligned reference.
//  Ports       : clk_in, rst_in (sync, active low)
//                step_in        - one pulse per sample period
//                ref_in, mic_in - signed samples, valid with step_in
//                delay_in, delay_valid_in - delay measurement, captured on
//                                 the rising edge of delay_valid_in
//                aligned_out, residual_out, out_valid - sample outputs,
//                                 out_valid one cycle after step_in
//                active_delay   - delay in use
//                locked         - alignment valid
//                clamped        - last captured delay exceeded DEPTH-1
//  Revision    : 1.0 - initial release
// ============================================================================
module sos_delay_aligner
    import sos_pkg::*;
#(
    parameter int DEPTH   = 512,
    parameter int DATA_W  = 16,
    parameter int DELAY_W = 12
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      step_in,
    input  logic signed [DATA_W-1:0]  ref_in,
    input  logic signed [DATA_W-1:0]  mic_in,
    input  logic [DELAY_W-1:0]        delay_in,
    input  logic                      delay_valid_in,
    output logic signed [DATA_W-1:0]  aligned_out,
    output logic signed [DATA_W-1:0]  residual_out,
    output logic                      out_valid,
    output logic [DELAY_W-1:0]        active_delay,
    output logic                      locked,
    output logic                      clamped
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW-1:0] MAX_DELAY = AW'(DEPTH - 1);

    align_state_t             state_q;
    logic [AW-1:0]            wr_ptr_q;
    logic [AW-1:0]            fill_cnt_q;
    logic [AW-1:0]            active_delay_q;
    logic [AW-1:0]            pending_delay_q;
    logic                     pending_flag_q;
    logic                     dv_prev_q;
    logic                     clamped_q;
    logic                     locked_q;
    logic                     out_valid_q;
    logic                     data_ok_q;
    logic                     bypass_q;
    logic signed [DATA_W-1:0] ref_q;
    logic signed [DATA_W-1:0] mic_q;

    logic                     w_capture;
    logic                     w_over;
    logic [AW-1:0]            w_cap_delay;
    logic                     w_apply;
    logic [AW-1:0]            w_new_delay;
    logic [AW-1:0]            fill_cnt_d;
    logic                     w_data_ok;
    logic [AW-1:0]            w_rd_addr;
    logic signed [DATA_W-1:0] w_rd_data;
    logic signed [DATA_W-1:0] w_aligned;

    // Delay capture: rising edge of the valid level only.
    assign w_capture   = delay_valid_in & ~dv_prev_q;
    assign w_over      = delay_in > DELAY_W'(DEPTH - 1);
    assign w_cap_delay = w_over ? MAX_DELAY : delay_in[AW-1:0];

    // A capture landing on a step cycle is applied at the end of that same
    // step, so it takes effect on the very next step rather than waiting a
    // further step for the pending flag.
    assign w_apply     = step_in & (w_capture | pending_flag_q);
    assign w_new_delay = w_capture ? w_cap_delay : pending_delay_q;

    assign fill_cnt_d  = (fill_cnt_q == MAX_DELAY) ? fill_cnt_q : fill_cnt_q + AW'(1);

    // The sample active_delay steps back exists once that many samples have
    // been written since reset; delay 0 is served by the bypass.
    assign w_data_ok   = (state_q != IDLE) && (fill_cnt_q >= active_delay_q);
    assign w_rd_addr   = wr_ptr_q - active_delay_q;

    sample_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_in    (clk_in),
        .we_in     (step_in),
        .waddr_in  (wr_ptr_q),
        .wdata_in  (ref_in),
        .re_in     (step_in),
        .raddr_in  (w_rd_addr),
        .rdata_out (w_rd_data)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            fill_cnt_q      <= '0;
            active_delay_q  <= '0;
            pending_delay_q <= '0;
            pending_flag_q  <= 1'b0;
            dv_prev_q       <= 1'b0;
            clamped_q       <= 1'b0;
            locked_q        <= 1'b0;
            out_valid_q     <= 1'b0;
            data_ok_q       <= 1'b0;
            bypass_q        <= 1'b0;
            ref_q           <= '0;
            mic_q           <= '0;
        end else begin
            dv_prev_q   <= delay_valid_in;
            out_valid_q <= step_in;

            if (w_capture) begin
                pending_delay_q <= w_cap_delay;
                pending_flag_q  <= 1'b1;
                clamped_q       <= w_over;
            end

            if (step_in) begin
                wr_ptr_q   <= wr_ptr_q + AW'(1);
                fill_cnt_q <= fill_cnt_d;
                ref_q      <= ref_in;
                mic_q      <= mic_in;
                data_ok_q  <= w_data_ok;
                bypass_q   <= (active_delay_q == '0);

                // Placed after the capture block so the apply clears the
                // flag even when a capture arrives on the same cycle.
                if (w_apply) begin
                    active_delay_q <= w_new_delay;
                    pending_flag_q <= 1'b0;
                end

                // Transitions are judged against fill_cnt_d, the count the
                // next step will compare with the new delay.
                case (state_q)
                    IDLE: begin
                        if (w_apply) begin
                            state_q <= FILLING;
                        end
                    end
                    FILLING: begin
                        if (w_data_ok && (!w_apply || (w_new_delay <= fill_cnt_d))) begin
                            state_q  <= ALIGNED;
                            locked_q <= 1'b1;
                        end
                    end
                    ALIGNED: begin
                        if (w_apply && (w_new_delay > fill_cnt_d)) begin
                            state_q  <= FILLING;
                            locked_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Every term below is a register that only moves on a step edge, so the
    // outputs hold between steps; rd data also holds since reads are gated.
    assign w_aligned    = data_ok_q ? (bypass_q ? ref_q : w_rd_data) : '0;
    assign aligned_out  = w_aligned;
    assign residual_out = DATA_W'(sat_sub(32'(mic_q), 32'(w_aligned), DATA_W));
    assign out_valid    = out_valid_q;
    assign active_delay = DELAY_W'(active_delay_q);
    assign locked       = locked_q;
    assign clamped      = clamped_q;

endmodule
`default_nettype wire
